// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: sequential signed multiply/divide unit with its own controller.
// The main control FSM of the multicycle MIPS datapath pulses start_mult or
// start_div and stalls while busy is high. Results are written to internal
// HI/LO registers, and done pulses once they have been updated.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   start_mult  begin signed MULT a*b (sampled only in idle)
//   start_div   begin signed DIV a/b (sampled only in idle; MULT wins if both)
//   a, b        operands rs/rt, captured when a start is accepted
//   busy        operation in progress
//   done        one-cycle pulse after HI/LO are updated
//   div_zero    one-cycle pulse when a DIV is started with b == 0
//   hi_out      HI register (product high word / remainder)
//   lo_out      LO register (product low word / quotient)
module mult_div_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {StIdle, StMult, StDiv, StFin} state_t;

  state_t r_state, w_state_next;

  // Shared working registers:
  //   multiply: r_acc_hi = A (one guard bit), r_acc_lo = Q, r_qm1 = q-1, r_opnd = multiplicand
  //   divide:   r_acc_hi = partial remainder, r_acc_lo = dividend/quotient, r_opnd = |divisor|
  logic [WIDTH:0]   r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic             r_qm1;
  logic [WIDTH-1:0] r_opnd;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_last;
  logic             w_opnd_zero;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH:0]   w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic             w_mul_qm1;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH:0]   w_div_hi;
  logic [WIDTH-1:0] w_div_lo;
  logic [WIDTH-1:0] w_quo_signed;
  logic [WIDTH-1:0] w_rem_signed;

  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_opnd_zero = (r_opnd == '0);

  // Unsigned magnitudes; the most negative value maps to 0x80000000 as required.
  assign w_abs_a = a[WIDTH-1] ? -a : a;
  assign w_abs_b = b[WIDTH-1] ? -b : b;

  // Booth step. A carries one guard bit so A - M cannot overflow when
  // M = -2^(WIDTH-1).
  assign w_m_ext = {r_opnd[WIDTH-1], r_opnd};

  always_comb begin
    w_booth_sum = r_acc_hi;
    unique case ({r_acc_lo[0], r_qm1})
      2'b01:   w_booth_sum = r_acc_hi + w_m_ext;
      2'b10:   w_booth_sum = r_acc_hi - w_m_ext;
      default: w_booth_sum = r_acc_hi;
    endcase
  end

  // Arithmetic right shift of {A, Q, q-1}.
  assign w_mul_hi  = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
  assign w_mul_lo  = {w_booth_sum[0], r_acc_lo[WIDTH-1:1]};
  assign w_mul_qm1 = r_acc_lo[0];

  // Restoring division step on magnitudes.
  assign w_shift  = {r_acc_hi[WIDTH-1:0], r_acc_lo[WIDTH-1]};
  assign w_ge     = (w_shift >= {1'b0, r_opnd});
  assign w_div_hi = w_ge ? (w_shift - {1'b0, r_opnd}) : w_shift;
  assign w_div_lo = {r_acc_lo[WIDTH-2:0], w_ge};

  // Truncating signs: quotient sign a^b, remainder follows the dividend.
  assign w_quo_signed = r_neg_q ? -w_div_lo : w_div_lo;
  assign w_rem_signed = r_neg_r ? -w_div_hi[WIDTH-1:0] : w_div_hi[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (start_mult) begin
          w_state_next = StMult;
        end else if (start_div) begin
          w_state_next = StDiv;
        end
      end
      StMult: begin
        if (w_last) w_state_next = StFin;
      end
      StDiv: begin
        // A zero divisor skips all iterations.
        if (w_opnd_zero || w_last) w_state_next = StFin;
      end
      StFin:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_qm1    <= 1'b0;
      r_opnd   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start_mult || start_div) begin
            r_cnt    <= '0;
            r_dz     <= 1'b0;
            r_acc_hi <= '0;
            r_qm1    <= 1'b0;
            if (start_mult) begin
              r_acc_lo <= a;
              r_opnd   <= b;
            end else begin
              r_acc_lo <= w_abs_a;
              r_opnd   <= w_abs_b;
              r_neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
              r_neg_r  <= a[WIDTH-1];
            end
          end
        end
        StMult: begin
          r_acc_hi <= w_mul_hi;
          r_acc_lo <= w_mul_lo;
          r_qm1    <= w_mul_qm1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_hi <= w_mul_hi[WIDTH-1:0];
            r_lo <= w_mul_lo;
          end
        end
        StDiv: begin
          if (w_opnd_zero) begin
            r_dz <= 1'b1;
          end else begin
            r_acc_hi <= w_div_hi;
            r_acc_lo <= w_div_lo;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_hi <= w_rem_signed;
              r_lo <= w_quo_signed;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == StMult) || (r_state == StDiv);
  assign done     = (r_state == StFin) && !r_dz;
  assign div_zero = (r_state == StFin) && r_dz;
  assign hi_out   = r_hi;
  assign lo_out   = r_lo;

endmodule

// File: tb/tb_mult_div_ctrl.sv
module tb_mult_div_ctrl;

  logic        clk;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_vec;
  int n_err;

  // Reference HI/LO contents.
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mult_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic, truncating division.
  task automatic model(input int kind, input logic [31:0] ia, input logic [31:0] ib);
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    if (kind != 1) begin
      p = sa * sb;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (ib != 32'd0) begin
      q = sa / sb;
      r = sa % sb;
      exp_lo = q[31:0];
      exp_hi = r[31:0];
    end
  endtask

  // kind: 0 = mult, 1 = div, 2 = both starts high. inject >= 0 fires a stray
  // start pulse that many cycles after acceptance.
  task automatic do_op(input int kind, input logic [31:0] ia, input logic [31:0] ib,
                       input int inject);
    int cyc;
    bit busy_ok;
    bit dz;
    dz = (kind == 1) && (ib == 32'd0);
    model(kind, ia, ib);
    start_mult = (kind != 1);
    start_div  = (kind != 0);
    a = ia;
    b = ib;
    tick();
    start_mult = 1'b0;
    start_div  = 1'b0;
    a = $urandom;
    b = $urandom;
    check("busy_after_start", 64'(busy), 64'd1);
    cyc = 0;
    busy_ok = 1'b1;
    while (!done && !div_zero && cyc < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (cyc == inject) begin
        start_mult = 1'b1;
        start_div  = 1'b1;
      end
      tick();
      start_mult = 1'b0;
      start_div  = 1'b0;
      cyc++;
    end
    if (dz) begin
      check("dz_latency", 64'(cyc), 64'd1);
      check("dz_flag", 64'(div_zero), 64'd1);
      check("dz_no_done", 64'(done), 64'd0);
    end else begin
      check("latency", 64'(cyc), 64'd32);
      check("done_pulse", 64'(done), 64'd1);
      check("no_div_zero", 64'(div_zero), 64'd0);
      check("busy_while_running", 64'(busy_ok), 64'd1);
    end
    check("busy_at_fin", 64'(busy), 64'd0);
    check("hi", 64'(hi_out), 64'(exp_hi));
    check("lo", 64'(lo_out), 64'(exp_lo));
    tick();
    check("pulse_one_cycle", {62'd0, done, div_zero}, 64'd0);
    check("idle_not_busy", 64'(busy), 64'd0);
    check("hi_hold", 64'(hi_out), 64'(exp_hi));
    check("lo_hold", 64'(lo_out), 64'(exp_lo));
  endtask

  initial begin
    int saw_done;
    int kind;
    logic [31:0] ra;
    logic [31:0] rb;
    n_vec = 0;
    n_err = 0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    reset = 1'b1;
    start_mult = 1'b0;
    start_div = 1'b0;
    a = 32'd0;
    b = 32'd0;
    tick();
    tick();
    check("rst_flags", {61'd0, busy, done, div_zero}, 64'd0);
    check("rst_hi", 64'(hi_out), 64'd0);
    check("rst_lo", 64'(lo_out), 64'd0);
    reset = 1'b0;
    tick();

    // Directed cases.
    do_op(0, 32'd7, 32'hFFFF_FFFD, -1);
    check("t1_lo_const", 64'(lo_out), 64'hFFFF_FFEB);
    do_op(0, 32'h8000_0000, 32'h8000_0000, 5);
    check("t2_hi_const", 64'(hi_out), 64'h4000_0000);
    do_op(1, 32'hFFFF_FFF9, 32'd2, -1);
    check("t3_lo_const", 64'(lo_out), 64'hFFFF_FFFD);
    do_op(0, 32'h66, 32'h2AAA_AAAB, -1);
    check("preload_hi", 64'(hi_out), 64'h11);
    check("preload_lo", 64'(lo_out), 64'h22);
    do_op(1, 32'd5, 32'd0, -1);
    check("dz_hi_kept", 64'(hi_out), 64'h11);
    do_op(2, 32'd3, 32'd2, -1);
    check("both_lo", 64'(lo_out), 64'd6);
    do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("wrap_lo", 64'(lo_out), 64'h8000_0000);

    // Reset in the middle of a divide.
    start_div = 1'b1;
    a = 32'd100;
    b = 32'd7;
    tick();
    start_div = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_hi", 64'(hi_out), 64'd0);
    check("mid_rst_lo", 64'(lo_out), 64'd0);
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || div_zero || busy) saw_done++;
      tick();
    end
    check("mid_rst_quiet", 64'(saw_done), 64'd0);
    do_op(1, 32'd100, 32'd7, -1);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      kind = int'($urandom_range(0, 2));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      do_op(kind, ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
